// File: rtl/atom_rr_scheduler.sv
// Round-robin scheduler and config/clear controller owning every input of one predicated RMW atom.
// Define ATOM_RR_SCHED_STATS_EN to add saturating grant/update counters (stat_grants, stat_updates).
module atom_rr_scheduler #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_pkt_1,
   input  logic [NREQ*32-1:0]   req_pkt_2,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic                 cfg_sel_1,
   input  logic [1:0]           cfg_sel_2,
   input  logic                 cfg_sel_3,
   input  logic [1:0]           cfg_sel_4,
   input  logic [1:0]           cfg_rel_opcode,
   input  logic [31:0]          cfg_cons_1,
   input  logic [31:0]          cfg_cons_2,
   input  logic                 clear_req,
   output logic [31:0]          atom_pkt_1,
   output logic [31:0]          atom_pkt_2,
   output logic [31:0]          atom_cons_1,
   output logic [31:0]          atom_cons_2,
   output logic                 atom_sel_1,
   output logic [1:0]           atom_sel_2,
   output logic                 atom_sel_3,
   output logic [1:0]           atom_sel_4,
   output logic [1:0]           atom_rel_opcode,
   input  logic [31:0]          atom_read,
   input  logic [31:0]          atom_write,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_old,
   output logic [31:0]          rsp_new,
   output logic                 busy
`ifdef ATOM_RR_SCHED_STATS_EN
   ,
   output logic [31:0]          stat_grants,
   output logic [31:0]          stat_updates
`endif
);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   typedef struct packed {
      logic        sel_1;
      logic [1:0]  sel_2;
      logic        sel_3;
      logic [1:0]  sel_4;
      logic [1:0]  rel_opcode;
      logic [31:0] cons_1;
      logic [31:0] cons_2;
   } cfg_t;

   state_t            state_reg, state_next;
   cfg_t              active_reg, shadow_reg, cfg_in;
   logic [IDW-1:0]    rr_ptr_reg;
   logic              rsp_valid_reg;
   logic [IDW-1:0]    rsp_id_reg;
   logic [31:0]       rsp_old_reg, rsp_new_reg;

   logic [31:0]       pkt_1_arr [NREQ];
   logic [31:0]       pkt_2_arr [NREQ];
   logic [IDW:0]      idx_wide;
   logic [IDW-1:0]    winner;
   logic              found;
   logic              grant_en;
   logic              cfg_fire;
   logic [NREQ-1:0]   one_hot;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign pkt_1_arr[gi] = req_pkt_1[32*gi +: 32];
         assign pkt_2_arr[gi] = req_pkt_2[32*gi +: 32];
      end
   endgenerate

   assign cfg_in = '{sel_1: cfg_sel_1, sel_2: cfg_sel_2, sel_3: cfg_sel_3, sel_4: cfg_sel_4,
                     rel_opcode: cfg_rel_opcode, cons_1: cfg_cons_1, cons_2: cfg_cons_2};

   // First valid requester at or after the pointer, wrapping at NREQ (NREQ need not be a power of 2).
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      idx_wide = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_wide = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
         if (idx_wide >= (IDW+1)'(NREQ))
            idx_wide = idx_wide - (IDW+1)'(NREQ);
         if (!found && req_valid[idx_wide[IDW-1:0]]) begin
            found  = 1'b1;
            winner = idx_wide[IDW-1:0];
         end
      end
   end

   // clear_req beats cfg_valid, which beats packets.
   assign grant_en  = (state_reg == ST_RUN) && !clear_req && !cfg_valid && found;
   assign cfg_ready = (state_reg == ST_RUN) && !clear_req;
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign one_hot   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
   assign req_ready = grant_en ? one_hot : '0;
   assign busy      = (state_reg != ST_RUN);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_CLEAR: state_next = ST_RUN;
         ST_RUN: begin
            if (clear_req)
               state_next = ST_CLEAR;
            else if (cfg_valid)
               state_next = ST_APPLY;
         end
         ST_APPLY: state_next = ST_RUN;
         default:  state_next = ST_CLEAR;
      endcase
   end

   // Atom inputs: idle hold (state != state) unless clearing or serving a grant.
   always_comb begin
      atom_pkt_1      = atom_read;
      atom_pkt_2      = '0;
      atom_cons_1     = active_reg.cons_1;
      atom_cons_2     = active_reg.cons_2;
      atom_sel_1      = 1'b0;
      atom_sel_2      = 2'd0;
      atom_sel_3      = active_reg.sel_3;
      atom_sel_4      = active_reg.sel_4;
      atom_rel_opcode = 2'd0;
      if (state_reg == ST_CLEAR) begin
         atom_pkt_1      = '0;
         atom_sel_1      = 1'b1;
         atom_sel_2      = 2'd2;
         atom_cons_1     = '0;
         atom_rel_opcode = 2'd3;
         atom_sel_3      = 1'b1;
         atom_sel_4      = 2'd2;
         atom_cons_2     = '0;
      end else if (grant_en) begin
         atom_pkt_1      = pkt_1_arr[winner];
         atom_pkt_2      = pkt_2_arr[winner];
         atom_sel_1      = active_reg.sel_1;
         atom_sel_2      = active_reg.sel_2;
         atom_rel_opcode = active_reg.rel_opcode;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_CLEAR;
         active_reg    <= '0;
         shadow_reg    <= '0;
         rr_ptr_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_old_reg   <= '0;
         rsp_new_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         rsp_valid_reg <= grant_en;
         if (cfg_fire)
            shadow_reg <= cfg_in;
         if (state_reg == ST_APPLY)
            active_reg <= shadow_reg;
         if (grant_en) begin
            rr_ptr_reg  <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
            rsp_id_reg  <= winner;
            rsp_old_reg <= atom_read;
            rsp_new_reg <= atom_write;
         end
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_old   = rsp_old_reg;
   assign rsp_new   = rsp_new_reg;

`ifdef ATOM_RR_SCHED_STATS_EN
   logic [31:0] stat_grants_reg, stat_updates_reg;

   // Counters survive CLEAR; only rst_n zeroes them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_grants_reg  <= '0;
         stat_updates_reg <= '0;
      end else if (grant_en) begin
         if (stat_grants_reg != '1)
            stat_grants_reg <= stat_grants_reg + 32'd1;
         if ((atom_write != atom_read) && (stat_updates_reg != '1))
            stat_updates_reg <= stat_updates_reg + 32'd1;
      end
   end

   assign stat_grants  = stat_grants_reg;
   assign stat_updates = stat_updates_reg;
`endif

endmodule

// File: tb/tb_atom_rr_scheduler.sv
// Directed bench for atom_rr_scheduler with a behavioural model of the stateful atom.
// Build with ATOM_RR_SCHED_STATS_EN to also check the statistics counters.
module tb_atom_rr_scheduler;
   localparam int NREQ = 4;
   localparam int IDW  = $clog2(NREQ);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [NREQ-1:0]     req_valid, req_ready;
   logic [NREQ*32-1:0]  req_pkt_1, req_pkt_2;
   logic                cfg_valid, cfg_ready;
   logic                cfg_sel_1, cfg_sel_3;
   logic [1:0]          cfg_sel_2, cfg_sel_4, cfg_rel_opcode;
   logic [31:0]         cfg_cons_1, cfg_cons_2;
   logic                clear_req;
   logic [31:0]         atom_pkt_1, atom_pkt_2, atom_cons_1, atom_cons_2;
   logic                atom_sel_1, atom_sel_3;
   logic [1:0]          atom_sel_2, atom_sel_4, atom_rel_opcode;
   logic [31:0]         atom_read, atom_write;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_old, rsp_new;
   logic                busy;
`ifdef ATOM_RR_SCHED_STATS_EN
   logic [31:0]         stat_grants, stat_updates;
`endif

   atom_rr_scheduler #(.NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_pkt_1(req_pkt_1), .req_pkt_2(req_pkt_2),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel_1(cfg_sel_1), .cfg_sel_2(cfg_sel_2), .cfg_sel_3(cfg_sel_3), .cfg_sel_4(cfg_sel_4),
      .cfg_rel_opcode(cfg_rel_opcode), .cfg_cons_1(cfg_cons_1), .cfg_cons_2(cfg_cons_2),
      .clear_req(clear_req),
      .atom_pkt_1(atom_pkt_1), .atom_pkt_2(atom_pkt_2),
      .atom_cons_1(atom_cons_1), .atom_cons_2(atom_cons_2),
      .atom_sel_1(atom_sel_1), .atom_sel_2(atom_sel_2), .atom_sel_3(atom_sel_3), .atom_sel_4(atom_sel_4),
      .atom_rel_opcode(atom_rel_opcode),
      .atom_read(atom_read), .atom_write(atom_write),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_old(rsp_old), .rsp_new(rsp_new),
      .busy(busy)
`ifdef ATOM_RR_SCHED_STATS_EN
      , .stat_grants(stat_grants), .stat_updates(stat_updates)
`endif
   );

   // Atom model: rel(mux(state,0), mux(pkt_1,pkt_2,cons_1)) ? mux(state,0)+mux(pkt_1,pkt_2,cons_2) : state
   logic [31:0] st = 32'hdeadbeef;
   logic [31:0] lhs_a, rhs_a, lhs_b, rhs_b;
   logic        pred;

   always_comb begin
      lhs_a = atom_sel_1 ? 32'd0 : st;
      case (atom_sel_2)
         2'd0:    rhs_a = atom_pkt_1;
         2'd1:    rhs_a = atom_pkt_2;
         default: rhs_a = atom_cons_1;
      endcase
      case (atom_rel_opcode)
         2'd0:    pred = (lhs_a != rhs_a);
         2'd1:    pred = (lhs_a <  rhs_a);
         2'd2:    pred = (lhs_a >  rhs_a);
         default: pred = (lhs_a == rhs_a);
      endcase
      lhs_b = atom_sel_3 ? 32'd0 : st;
      case (atom_sel_4)
         2'd0:    rhs_b = atom_pkt_1;
         2'd1:    rhs_b = atom_pkt_2;
         default: rhs_b = atom_cons_2;
      endcase
      atom_write = pred ? (lhs_b + rhs_b) : st;
   end

   assign atom_read = st;
   always @(posedge clk) st <= atom_write;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_pkt(input int i, input logic [31:0] p1, input logic [31:0] p2);
      req_pkt_1[32*i +: 32] = p1;
      req_pkt_2[32*i +: 32] = p2;
   endtask

   task automatic check_rsp(input string tag, input int id, input logic [31:0] old_v, input logic [31:0] new_v);
      $display("rsp %s: valid=%0b id=%0d old=%0h new=%0h", tag, rsp_valid, rsp_id, rsp_old, rsp_new);
      check({tag, "_valid"}, 32'(rsp_valid), 1);
      check({tag, "_id"},    32'(rsp_id), 32'(id));
      check({tag, "_old"},   rsp_old, old_v);
      check({tag, "_new"},   rsp_new, new_v);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_pkt_1 = '0; req_pkt_2 = '0;
      cfg_valid = 1'b0; cfg_sel_1 = 1'b0; cfg_sel_2 = 2'd0; cfg_sel_3 = 1'b0; cfg_sel_4 = 2'd0;
      cfg_rel_opcode = 2'd0; cfg_cons_1 = '0; cfg_cons_2 = '0; clear_req = 1'b0;

      // Reset values
      step(); step();
      check("rst_busy",      32'(busy), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_id",    32'(rsp_id), 0);
      check("rst_rsp_old",   rsp_old, 0);
      check("rst_rsp_new",   rsp_new, 0);
      check("rst_cons_2",    atom_cons_2, 0);
      rst_n = 1'b1;
      settle();
      check("release_busy", 32'(busy), 1);
      step();
      check("run_busy",    32'(busy), 0);
      check("clear_state", st, 0);

      // Config: state < pkt_1 ? state + 1
      cfg_sel_1 = 1'b0; cfg_sel_2 = 2'd0; cfg_rel_opcode = 2'd1;
      cfg_sel_3 = 1'b0; cfg_sel_4 = 2'd2; cfg_cons_1 = 32'd0; cfg_cons_2 = 32'd1;
      cfg_valid = 1'b1;
      settle();
      check("cfg_ready", 32'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
      check("apply_busy", 32'(busy), 1);
      step();
      check("apply_done_busy", 32'(busy), 0);
      check("active_sel_4",    32'(atom_sel_4), 2);
      check("active_cons_2",   atom_cons_2, 1);
      check("apply_hold",      st, 0);

      // Three back-to-back packets from requester 0
      set_pkt(0, 32'd5, 32'd0);
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("b2b_ready", 32'(req_ready), 1);
         step();
         check_rsp("b2b", 0, 32'(k), 32'(k + 1));
      end
      req_valid = '0;
      step();
      check("b2b_idle_rsp", 32'(rsp_valid), 0);

      // Predicate false: 3 < 2 -> hold
      set_pkt(1, 32'd2, 32'd0);
      req_valid = 4'b0010;
      settle();
      check("false_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      check_rsp("false", 1, 32'd3, 32'd3);
`ifdef ATOM_RR_SCHED_STATS_EN
      check("stat_grants_4",  stat_grants, 4);
      check("stat_updates_3", stat_updates, 3);
`endif

      // All four requesters: pointer now at 2
      for (int i = 0; i < NREQ; i++) set_pkt(i, 32'd100, 32'd0);
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         int w;
         w = (2 + k) % NREQ;
         settle();
         check("rr_ready", 32'(req_ready), 32'(1 << w));
         step();
         check_rsp("rr", w, 32'(3 + k), 32'(4 + k));
      end
      req_valid = '0;
      step();
      check("rr_idle_rsp", 32'(rsp_valid), 0);

      // clear + cfg + packet together: state==cons_1(0) ? 0 + pkt_2
      cfg_sel_1 = 1'b0; cfg_sel_2 = 2'd2; cfg_rel_opcode = 2'd3; cfg_cons_1 = 32'd0;
      cfg_sel_3 = 1'b1; cfg_sel_4 = 2'd1; cfg_cons_2 = 32'd5;
      set_pkt(0, 32'd100, 32'd77);
      clear_req = 1'b1; cfg_valid = 1'b1; req_valid = 4'b0001;
      settle();
      check("tri_ready",     32'(req_ready), 0);
      check("tri_cfg_ready", 32'(cfg_ready), 0);
      step();
      clear_req = 1'b0;
      settle();
      check("clr_busy",     32'(busy), 1);
      check("clr_ready",    32'(req_ready), 0);
      check("clr_rel",      32'(atom_rel_opcode), 3);
      check("clr_no_rsp",   32'(rsp_valid), 0);
      step();
      settle();
      check("clr_state",     st, 0);
      check("post_cfg_ready", 32'(cfg_ready), 1);
      check("post_req_ready", 32'(req_ready), 0);
      step();
      cfg_valid = 1'b0;
      clear_req = 1'b1;
      settle();
      check("apply2_busy",  32'(busy), 1);
      check("apply2_ready", 32'(req_ready), 0);
      step();
      clear_req = 1'b0;
      settle();
      check("clear_dropped", 32'(busy), 0);
      check("new_cfg_ready", 32'(req_ready), 1);
      step();
      req_valid = '0;
      check_rsp("newcfg", 0, 32'd0, 32'd77);

      // Clear, load state 7, then idle for 10 cycles
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      step();
      set_pkt(0, 32'd0, 32'd7);
      req_valid = 4'b0001;
      settle();
      check("load7_ready", 32'(req_ready), 1);
      step();
      req_valid = '0;
      check_rsp("load7", 0, 32'd0, 32'd7);
`ifdef ATOM_RR_SCHED_STATS_EN
      check("stat_grants_14",  stat_grants, 14);
      check("stat_updates_13", stat_updates, 13);
`endif
      for (int k = 0; k < 10; k++) begin
         step();
         check("idle_rsp",   32'(rsp_valid), 0);
         check("idle_state", st, 7);
      end
      check("idle_pkt_1", atom_pkt_1, 7);

      // Reset during APPLY discards the pending config
      cfg_sel_4 = 2'd2; cfg_cons_2 = 32'h1234; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_busy",  32'(busy), 1);
      check("abort_sel_1", 32'(atom_sel_1), 1);
      step();
      check("abort_run",    32'(busy), 0);
      check("abort_cons_2", atom_cons_2, 0);
      check("abort_sel_4",  32'(atom_sel_4), 0);
`ifdef ATOM_RR_SCHED_STATS_EN
      check("stat_rst", stat_grants, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
